// File: rtl/mcdt_slave_fifo_param.sv
// Per-channel slave FIFO for the MCDT datapath: buffers channel words and
// hands them to the arbiter as fixed-length bursts.
module mcdt_slave_fifo_param #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned AF_LVL = 4,
  parameter int unsigned LW     = 5
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [DW-1:0] chx_data_i,
  input  logic          chx_valid_i,
  output logic          chx_ready_o,
  input  logic          slvx_en_i,
  input  logic [LW-1:0] slvx_pkt_len_i,
  input  logic          slvx_flush_i,
  input  logic          a2sx_ack_i,
  output logic          slvx_req_o,
  output logic          slvx_val_o,
  output logic [DW-1:0] slvx_data_o,
  output logic [AW:0]   slvx_margin_o,
  output logic          slvx_afull_o,
  output logic          slvx_err_o
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned CW    = (LW > PW) ? LW : PW;

  typedef enum logic [1:0] {IDLE, REQ, BURST} state_e;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic [PW-1:0] burst_cnt;
  logic          full;
  logic          empty;
  logic          wr_acc;
  logic          rd_acc;
  logic [CW-1:0] len_ext;
  logic [CW-1:0] eff_len;
  state_e        state;

  // Extra pointer MSB distinguishes full from empty across wraps
  assign count         = wr_ptr - rd_ptr;
  assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty         = (wr_ptr == rd_ptr);
  assign chx_ready_o   = ~full & ~slvx_flush_i;
  assign wr_acc        = chx_valid_i & chx_ready_o;
  assign rd_acc        = a2sx_ack_i & ~empty & ~slvx_flush_i;
  assign slvx_margin_o = PW'(DEPTH) - count;
  assign slvx_afull_o  = (slvx_margin_o <= PW'(AF_LVL));

  // Burst length: zero means one word, clipped to the FIFO depth
  always_comb begin
    len_ext = CW'(slvx_pkt_len_i);
    eff_len = len_ext;
    if (len_ext == '0) begin
      eff_len = CW'(1);
    end else if (len_ext > CW'(DEPTH)) begin
      eff_len = CW'(DEPTH);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= chx_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      burst_cnt   <= '0;
      state       <= IDLE;
      slvx_req_o  <= 1'b0;
      slvx_val_o  <= 1'b0;
      slvx_data_o <= '0;
      slvx_err_o  <= 1'b0;
    end else if (slvx_flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      burst_cnt  <= '0;
      state      <= IDLE;
      slvx_req_o <= 1'b0;
      slvx_val_o <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      slvx_val_o <= rd_acc;
      if (rd_acc) begin
        rd_ptr      <= rd_ptr + PW'(1);
        slvx_data_o <= mem[rd_ptr[AW-1:0]];
      end
      if (a2sx_ack_i && empty) begin
        slvx_err_o <= 1'b1;
      end
      // Enable gates only new requests; a started burst always completes
      case (state)
        IDLE: begin
          if (slvx_en_i && (CW'(count) >= eff_len)) begin
            state      <= REQ;
            slvx_req_o <= 1'b1;
            burst_cnt  <= PW'(eff_len);
          end
        end
        REQ: begin
          if (rd_acc) begin
            burst_cnt <= burst_cnt - PW'(1);
            if (burst_cnt == PW'(1)) begin
              state      <= IDLE;
              slvx_req_o <= 1'b0;
            end else begin
              state <= BURST;
            end
          end else if (!slvx_en_i) begin
            state      <= IDLE;
            slvx_req_o <= 1'b0;
          end
        end
        BURST: begin
          if (rd_acc) begin
            burst_cnt <= burst_cnt - PW'(1);
            if (burst_cnt == PW'(1)) begin
              state      <= IDLE;
              slvx_req_o <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          slvx_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcdt_slave_fifo_param.sv
// Directed bench for mcdt_slave_fifo_param with hand-computed expectations.
module tb_mcdt_slave_fifo_param;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned LW = 5;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] chx_data;
  logic          chx_valid;
  logic          chx_ready;
  logic          en;
  logic [LW-1:0] pkt_len;
  logic          flush;
  logic          ack;
  logic          req;
  logic          val;
  logic [DW-1:0] data;
  logic [AW:0]   margin;
  logic          afull;
  logic          err;

  int n_assert = 0;
  int n_fail   = 0;

  mcdt_slave_fifo_param #(.DW(DW), .AW(AW), .AF_LVL(4), .LW(LW)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .chx_data_i    (chx_data),
    .chx_valid_i   (chx_valid),
    .chx_ready_o   (chx_ready),
    .slvx_en_i     (en),
    .slvx_pkt_len_i(pkt_len),
    .slvx_flush_i  (flush),
    .a2sx_ack_i    (ack),
    .slvx_req_o    (req),
    .slvx_val_o    (val),
    .slvx_data_o   (data),
    .slvx_margin_o (margin),
    .slvx_afull_o  (afull),
    .slvx_err_o    (err)
  );

  always #5 clk = ~clk;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_m(input string tag, input logic [AW:0] obs, input logic [AW:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_words(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      chx_valid = 1'b1;
      chx_data  = base + DW'(i);
      step();
    end
    chx_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; chx_data = '0; chx_valid = 1'b0; en = 1'b0;
    pkt_len = '0; flush = 1'b0; ack = 1'b0;
    #2;
    chk_b("rst_req", req, 1'b0);
    chk_b("rst_val", val, 1'b0);
    chk_b("rst_err", err, 1'b0);
    chk_b("rst_afull", afull, 1'b0);
    chk_b("rst_ready", chx_ready, 1'b1);
    chk_d("rst_data", data, 32'd0);
    chk_m("rst_margin", margin, 6'd32);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Fill to full with valid held
    for (int i = 0; i < 32; i++) begin
      chk_b("fill_ready", chx_ready, 1'b1);
      chx_valid = 1'b1;
      chx_data  = DW'(i);
      step();
      chk_m("fill_margin", margin, 6'(31 - i));
      chk_b("fill_afull", afull, (31 - i) <= 4);
    end
    chk_b("full_ready", chx_ready, 1'b0);
    chx_data = 32'd99;
    step();
    chk_m("full_no_write", margin, 6'd0);

    // Full with valid and ack together: only the read happens
    chx_data = 32'd32;
    ack      = 1'b1;
    chk_b("full_rw_ready", chx_ready, 1'b0);
    step();
    chk_b("full_rw_val", val, 1'b1);
    chk_d("full_rw_data", data, 32'd0);
    chk_m("full_rw_margin", margin, 6'd1);

    // Streaming across pointer wrap
    for (int k = 0; k < 100; k++) begin
      chx_data = DW'(32 + k);
      step();
      chk_d("stream_data", data, DW'(k + 1));
      chk_m("stream_margin", margin, 6'd1);
    end
    chx_valid = 1'b0;
    for (int j = 0; j < 31; j++) begin
      step();
      chk_d("drain_data", data, DW'(101 + j));
      chk_m("drain_margin", margin, 6'(j + 2));
    end

    // Ack on empty
    step();
    ack = 1'b0;
    chk_b("uf_err", err, 1'b1);
    chk_b("uf_val", val, 1'b0);
    chk_m("uf_margin", margin, 6'd32);
    flush = 1'b1;
    #1;
    chk_b("flush_ready", chx_ready, 1'b0);
    step();
    flush = 1'b0;
    chk_b("flush_err_sticky", err, 1'b1);
    @(posedge clk);
    #1 rstn = 1'b0;
    #2;
    chk_b("rst_clr_err", err, 1'b0);
    rstn = 1'b1;
    step();

    // Burst gating at pkt_len=4
    en = 1'b1; pkt_len = 5'd4;
    write_words(32'hA0, 3);
    step();
    chk_b("len3_req", req, 1'b0);
    write_words(32'hA3, 1);
    step();
    chk_b("len4_req", req, 1'b1);
    ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_b("burst_val", val, 1'b1);
      chk_d("burst_data", data, 32'hA0 + DW'(i));
      chk_b("burst_req", req, i < 3);
    end
    ack = 1'b0;
    step();
    chk_b("burst_val_end", val, 1'b0);
    chk_b("burst_req_end", req, 1'b0);

    // Flush mid-burst
    write_words(32'hB0, 4);
    step();
    chk_b("fl_req", req, 1'b1);
    ack = 1'b1;
    step();
    step();
    chk_d("fl_data", data, 32'hB1);
    ack = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    chk_b("fl_req_clr", req, 1'b0);
    chk_b("fl_val_clr", val, 1'b0);
    chk_m("fl_margin", margin, 6'd32);

    // Enable dropped mid-burst: burst still completes
    write_words(32'hC0, 4);
    step();
    chk_b("en_req", req, 1'b1);
    ack = 1'b1;
    step();
    step();
    en = 1'b0;
    step();
    chk_d("en_data2", data, 32'hC2);
    chk_b("en_req_hold", req, 1'b1);
    step();
    chk_d("en_data3", data, 32'hC3);
    chk_b("en_req_done", req, 1'b0);
    ack = 1'b0;
    step();
    chk_m("en_margin", margin, 6'd32);

    // pkt_len 0 acts as 1; enable drop in REQ aborts the request
    en = 1'b1; pkt_len = 5'd0;
    write_words(32'hE0, 1);
    step();
    chk_b("len0_req", req, 1'b1);
    en = 1'b0;
    step();
    chk_b("req_abort", req, 1'b0);
    en = 1'b1;
    step();
    chk_b("req_again", req, 1'b1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk_d("len1_data", data, 32'hE0);
    chk_b("len1_req", req, 1'b0);

    // Async reset mid-burst, half full, err set
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk_b("pre_err", err, 1'b1);
    pkt_len = 5'd4;
    write_words(32'h100, 16);
    ack = 1'b1;
    step();
    step();
    chk_b("ar_val_pre", val, 1'b1);
    chk_b("ar_req_pre", req, 1'b1);
    chk_m("ar_margin_pre", margin, 6'd18);
    rstn = 1'b0;
    #2;
    chk_b("ar_req", req, 1'b0);
    chk_b("ar_val", val, 1'b0);
    chk_b("ar_err", err, 1'b0);
    chk_m("ar_margin", margin, 6'd32);
    chk_d("ar_data", data, 32'd0);
    ack = 1'b0;
    rstn = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
